// File: rtl/log_mul_20s16a.sv
// Dual-channel (I/Q) gain stage. Each signed 20-bit sample is scaled by a shared
// floating-point gain. The product is formed in the log2 domain (Mitchell
// approximation), so no multipliers are used. Outputs are saturated to a
// symmetric signed 16-bit range.
// Pipeline: input regs -> log of |din| -> log add -> antilog -> sign/out regs.
module log_mul_20s16a (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] dix,
  input  logic [19:0] diy,
  input  logic        iv,
  input  logic [15:0] gain,
  output logic [15:0] dox,
  output logic [15:0] doy,
  output logic        ov
);

  // stage 0: captured inputs
  logic [1:0][19:0] r0_d;
  logic [15:0]      r0_g;
  logic             r0_v;

  // stage 1: sign, leading-one index, log fraction
  logic [1:0]       w1_s;
  logic [1:0][19:0] w1_a;
  logic [1:0][4:0]  w1_k;
  logic [1:0][11:0] w1_fa;
  logic [1:0]       w1_z;
  logic [1:0]       r1_s;
  logic [1:0][4:0]  r1_k;
  logic [1:0][11:0] r1_fa;
  logic [1:0]       r1_z;
  logic [3:0]       r1_e;
  logic [11:0]      r1_fg;
  logic             r1_v;

  // stage 2: log sum, exponent kept biased by +5 (nb = n + 5) to stay unsigned
  logic [1:0][12:0] w2_sum;
  logic [1:0][5:0]  w2_nb;
  logic [1:0][5:0]  r2_nb;
  logic [1:0][11:0] r2_f;
  logic [1:0]       r2_s;
  logic [1:0]       r2_z;
  logic             r2_v;

  // stage 3: antilog magnitude
  logic [1:0][15:0] w3_m;
  logic [1:0][14:0] w3_r;
  logic [1:0][14:0] r3_r;
  logic [1:0]       r3_s;
  logic [1:0]       r3_z;
  logic             r3_v;

  // register inputs and the input valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_d <= '0;
      r0_g <= '0;
      r0_v <= 1'b0;
    end else begin
      r0_d[0] <= dix;
      r0_d[1] <= diy;
      r0_g    <= gain;
      r0_v    <= iv;
    end
  end

  // magnitude, leading-one position and the 12 fraction bits below it
  always_comb begin
    w1_s  = '0;
    w1_a  = '0;
    w1_k  = '0;
    w1_fa = '0;
    w1_z  = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      w1_s[c] = r0_d[c][19];
      w1_a[c] = w1_s[c] ? (20'd0 - r0_d[c]) : r0_d[c];
      for (int unsigned b = 0; b < 20; b++) begin
        if (w1_a[c][b]) w1_k[c] = 5'(b);
      end
      // normalise so the leading one lands on bit 19; the fraction is bits 18:7
      w1_fa[c] = 12'(({12'b0, w1_a[c]} << (5'd19 - w1_k[c])) >> 7);
      w1_z[c]  = (w1_a[c] == 20'd0) || !r0_g[11];
    end
  end

  // register log of operands; gain log fraction drops the implicit M[11]
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_s  <= '0;
      r1_k  <= '0;
      r1_fa <= '0;
      r1_z  <= '0;
      r1_e  <= '0;
      r1_fg <= '0;
      r1_v  <= 1'b0;
    end else begin
      r1_s  <= w1_s;
      r1_k  <= w1_k;
      r1_fa <= w1_fa;
      r1_z  <= w1_z;
      r1_e  <= r0_g[15:12];
      r1_fg <= {r0_g[10:0], 1'b0};
      r1_v  <= r0_v;
    end
  end

  // add the logs; nb = k + (E-1) - 4 + carry + 5 = k + E + carry
  always_comb begin
    w2_sum = '0;
    w2_nb  = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      w2_sum[c] = {1'b0, r1_fa[c]} + {1'b0, r1_fg};
      w2_nb[c]  = 6'(r1_k[c]) + 6'(r1_e) + {5'd0, w2_sum[c][12]};
    end
  end

  // register log sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r2_nb <= '0;
      r2_f  <= '0;
      r2_s  <= '0;
      r2_z  <= '0;
      r2_v  <= 1'b0;
    end else begin
      r2_nb <= w2_nb;
      for (int unsigned c = 0; c < 2; c++) r2_f[c] <= w2_sum[c][11:0];
      r2_s  <= r1_s;
      r2_z  <= r1_z;
      r2_v  <= r1_v;
    end
  end

  // antilog: (4096+f) * 2^(n-12); n >= 15 saturates, n <= 14 never exceeds 32767
  always_comb begin
    w3_m = '0;
    w3_r = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      w3_m[c] = {3'b0, 1'b1, r2_f[c]};
      if (r2_nb[c] >= 6'd20)
        w3_r[c] = 15'h7FFF;
      else if (r2_nb[c] >= 6'd17)
        w3_r[c] = 15'(w3_m[c] << (r2_nb[c] - 6'd17));
      else
        w3_r[c] = 15'(w3_m[c] >> (6'd17 - r2_nb[c]));
    end
  end

  // register antilog magnitude
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r3_r <= '0;
      r3_s <= '0;
      r3_z <= '0;
      r3_v <= 1'b0;
    end else begin
      r3_r <= w3_r;
      r3_s <= r2_s;
      r3_z <= r2_z;
      r3_v <= r2_v;
    end
  end

  // apply sign and zero-forcing; outputs hold between valid cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dox <= '0;
      doy <= '0;
      ov  <= 1'b0;
    end else begin
      ov <= r3_v;
      if (r3_v) begin
        dox <= r3_z[0] ? '0 : (r3_s[0] ? (16'd0 - {1'b0, r3_r[0]}) : {1'b0, r3_r[0]});
        doy <= r3_z[1] ? '0 : (r3_s[1] ? (16'd0 - {1'b0, r3_r[1]}) : {1'b0, r3_r[1]});
      end
    end
  end

endmodule

// File: tb/tb_log_mul_20s16a.sv
// Randomised bench for log_mul_20s16a with an arithmetic reference model,
// directed cases, a gain sweep and a mid-stream reset.
module tb_log_mul_20s16a;

  logic        clk;
  logic        rst;
  logic [19:0] dix;
  logic [19:0] diy;
  logic        iv;
  logic [15:0] gain;
  logic [15:0] dox;
  logic [15:0] doy;
  logic        ov;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned cyc;

  typedef struct {
    longint      x;
    longint      y;
    int unsigned smp_cyc;
  } exp_t;

  exp_t   q[$];
  longint last_x;
  longint last_y;

  log_mul_20s16a dut (
    .clk  (clk),
    .rst  (rst),
    .dix  (dix),
    .diy  (diy),
    .iv   (iv),
    .gain (gain),
    .dox  (dox),
    .doy  (doy),
    .ov   (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge counter used for latency checks
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: log2 of both operands, add, antilog, saturate.
  function automatic longint ref_mul(input longint d, input longint g);
    longint a, m, fa, fg, ff, f, r;
    int     k, e, n, c;
    bit     s;
    s = (d < 0);
    a = s ? -d : d;
    e = int'(g / 4096);
    m = g % 4096;
    if (a == 0 || m < 2048) return 0;
    k = 0;
    while ((longint'(1) << (k + 1)) <= a) k++;
    fa = ((a - (longint'(1) << k)) * 4096) / (longint'(1) << k);
    fg = (m - 2048) * 2;
    ff = fa + fg;
    c  = (ff >= 4096) ? 1 : 0;
    f  = ff - 4096 * c;
    n  = k + (e - 1) - 4 + c;
    if (n < -13)     r = 0;
    else if (n >= 0) r = ((4096 + f) * (longint'(1) << n)) / 4096;
    else             r = (4096 + f) / (longint'(4096) << (-n));
    if (n >= 15 || r > 32767) r = 32767;
    return s ? -r : r;
  endfunction

  task automatic drive(input bit v, input logic [19:0] x, input logic [19:0] y,
                       input logic [15:0] g);
    exp_t e;
    @(posedge clk); #1;
    iv   = v;
    dix  = x;
    diy  = y;
    gain = g;
    if (v) begin
      e.x = ref_mul(longint'($signed(x)), longint'(g));
      e.y = ref_mul(longint'($signed(y)), longint'(g));
      e.smp_cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      drive(1'b0, 20'($urandom), 20'($urandom), 16'($urandom));
  endtask

  // output monitor: every ov pulse must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("rst_ov", longint'(ov), 0);
      check("rst_dox", longint'($signed(dox)), 0);
      check("rst_doy", longint'($signed(doy)), 0);
      last_x = 0;
      last_y = 0;
    end else if (ov) begin
      if (q.size() == 0) begin
        check("spurious_ov", 1, 0);
      end else begin
        e = q.pop_front();
        check("dox", longint'($signed(dox)), e.x);
        check("doy", longint'($signed(doy)), e.y);
        check("latency", longint'(cyc - e.smp_cyc), 4);
        last_x = e.x;
        last_y = e.y;
      end
    end else begin
      check("hold_dox", longint'($signed(dox)), last_x);
      check("hold_doy", longint'($signed(doy)), last_y);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] x;
    logic [15:0] g;
    int unsigned mode;
    int unsigned tries;
    logic [19:0] sweep_d [5];

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    last_x   = 0;
    last_y   = 0;
    rst  = 1'b0;
    iv   = 1'b0;
    dix  = '0;
    diy  = '0;
    gain = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(3);

    // directed cases
    drive(1'b1, 20'd256, -20'sd256, 16'h4800);
    idle(6);
    drive(1'b1, 20'd65536, -20'sd65536, 16'h0800);
    drive(1'b1, 20'd1, -20'sd1, 16'h0800);
    drive(1'b1, 20'd4096, -20'sd4096, 16'h8800);
    drive(1'b1, 20'd16, -20'sd16, 16'h8800);
    drive(1'b1, 20'd12345, -20'sd777, 16'h4000);
    drive(1'b1, 20'd0, 20'd0, 16'hFFFF);
    drive(1'b1, 20'd3, -20'sd3, 16'h5C00);
    drive(1'b1, 20'h80000, 20'h7FFFF, 16'h0800);
    drive(1'b1, 20'h80000, 20'h7FFFF, 16'hFFFF);
    idle(6);

    // gain sweep
    sweep_d[0] = 20'd1;
    sweep_d[1] = 20'd16;
    sweep_d[2] = 20'd256;
    sweep_d[3] = 20'd4096;
    sweep_d[4] = 20'd65536;
    for (int unsigned gi = 0; gi <= 16'hF800; gi += 16'h0800)
      for (int unsigned di = 0; di < 5; di++)
        drive(1'b1, sweep_d[di], 20'd0 - sweep_d[di], 16'(gi));
    idle(6);

    // random traffic
    for (int unsigned i = 0; i < 400; i++) begin
      g = 16'($urandom);
      if ($urandom_range(0, 3) != 0) g[11] = 1'b1;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       x = 20'($urandom);
        1:       x = 20'($urandom_range(0, 64)) - 20'd32;
        2:       x = ($urandom_range(0, 1) != 0) ? 20'h80000 : 20'h7FFFF;
        default: x = 20'(($urandom & 32'hFFF) << $urandom_range(0, 8));
      endcase
      drive($urandom_range(0, 3) != 0, x, 20'($urandom), g);
    end

    // reset while samples are in flight: none of them may emerge
    drive(1'b1, 20'd1000, 20'd2000, 16'h5800);
    drive(1'b1, 20'd3000, 20'd4000, 16'h5800);
    @(posedge clk); #1;
    rst = 1'b0;
    iv  = 1'b0;
    q.delete();
    idle(3);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(8);
    drive(1'b1, 20'd512, -20'sd1024, 16'h5800);

    // drain with a bounded wait
    tries = 0;
    while (q.size() != 0 && tries < 20) begin
      idle(1);
      tries++;
    end
    check("drain_empty", longint'(q.size()), 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
